gb_sequencer: RTL and testbench

- Command-driven controller that sequences the accelerator global buffer through its data port.
- Accepts one instruction per command (global_buffer_instruction_t encoding) with a word count, and maintains region pointers for weights, activations and outputs.
- Drives buffer write strobes from an upstream stream and buffer reads toward a downstream sink.
- Sits between the top-level accelerator controller and the global buffer.

---
 rtl/gb_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_gb_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_sequencer.sv
// rtl/gb_sequencer.sv - command-driven global buffer sequencer (region pointers, write/read strobes)
module gb_sequencer #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_SIZE       = 8,
    parameter int INTERFACE_DEPTH = 16,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [3:0]                           cmd_instr,
    input  logic [LEN_WIDTH-1:0]                 cmd_len,
    input  logic [ADDR_WIDTH-1:0]                weight_start_addr,
    input  logic [ADDR_WIDTH-1:0]                activation_start_addr,
    input  logic [ADDR_WIDTH-1:0]                output_start_addr,
    input  logic                                 src_valid,
    output logic                                 src_ready,
    input  logic [DATA_SIZE*INTERFACE_DEPTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0]                buf_addr,
    output logic                                 buf_wr_en,
    output logic [DATA_SIZE*INTERFACE_DEPTH-1:0] buf_wr_data,
    output logic                                 buf_rd_en,
    input  logic [DATA_SIZE*INTERFACE_DEPTH-1:0] buf_rd_data,
    input  logic                                 buf_rd_data_valid,
    input  logic                                 rd_out_ready,
    output logic                                 rd_out_valid,
    output logic [DATA_SIZE*INTERFACE_DEPTH-1:0] rd_out_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int W = DATA_SIZE * INTERFACE_DEPTH;

    localparam logic [3:0] I_NOP             = 4'd0;
    localparam logic [3:0] I_POINTER_RESET   = 4'd1;
    localparam logic [3:0] I_LOAD_WEIGHT     = 4'd2;
    localparam logic [3:0] I_LOAD_ACTIVATION = 4'd3;
    localparam logic [3:0] I_LOAD_OUTPUT     = 4'd4;
    localparam logic [3:0] I_READ_ACTIVATION = 4'd5;

    localparam logic [1:0] R_WEIGHT     = 2'd0;
    localparam logic [1:0] R_ACTIVATION = 2'd1;
    localparam logic [1:0] R_OUTPUT     = 2'd2;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] aptr_q, aptr_d;
    logic [ADDR_WIDTH-1:0] optr_q, optr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [1:0]            region_q, region_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_ptr;
    logic                  wr_beat;
    logic                  rd_issue;

    // cmd_ready is forced low while nrst is asserted, so gate it directly on the pin
    assign accept   = cmd_valid && (state_q == S_IDLE) && nrst;
    assign wr_beat  = (state_q == S_WRITE) && src_valid;
    assign rd_issue = (state_q == S_READ) && rd_out_ready;

    // Pointer of the region the current LOAD targets
    always_comb begin
        sel_ptr = optr_q;
        case (region_q)
            R_WEIGHT:     sel_ptr = wptr_q;
            R_ACTIVATION: sel_ptr = aptr_q;
            default:      sel_ptr = optr_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; zero-length and undefined commands go straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_instr)
                        I_LOAD_WEIGHT, I_LOAD_ACTIVATION, I_LOAD_OUTPUT:
                            state_d = (cmd_len == LEN_ZERO) ? S_DONE : S_WRITE;
                        I_READ_ACTIVATION:
                            state_d = (cmd_len == LEN_ZERO) ? S_DONE : S_READ;
                        default:
                            state_d = S_DONE;
                    endcase
                end
            end
            S_WRITE: if (src_valid && remaining_q == LEN_ONE) state_d = S_DONE;
            S_READ:  if (rd_out_ready && remaining_q == LEN_ONE) state_d = S_DRAIN;
            S_DRAIN: if (buf_rd_data_valid) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: region pointers, beat counter, error flag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q      <= '0;
            aptr_q      <= '0;
            optr_q      <= '0;
            rptr_q      <= '0;
            remaining_q <= '0;
            region_q    <= R_WEIGHT;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            aptr_q      <= aptr_d;
            optr_q      <= optr_d;
            rptr_q      <= rptr_d;
            remaining_q <= remaining_d;
            region_q    <= region_d;
            err_q       <= err_d;
        end
    end

    // Datapath next values; pointers persist across commands and wrap silently
    always_comb begin
        wptr_d      = wptr_q;
        aptr_d      = aptr_q;
        optr_d      = optr_q;
        rptr_d      = rptr_q;
        remaining_d = remaining_q;
        region_d    = region_q;
        err_d       = 1'b0;
        if (accept) begin
            case (cmd_instr)
                I_NOP: ;
                I_POINTER_RESET: begin
                    wptr_d = weight_start_addr;
                    aptr_d = activation_start_addr;
                    optr_d = output_start_addr;
                    rptr_d = activation_start_addr;
                end
                I_LOAD_WEIGHT: begin
                    remaining_d = cmd_len;
                    region_d    = R_WEIGHT;
                end
                I_LOAD_ACTIVATION: begin
                    remaining_d = cmd_len;
                    region_d    = R_ACTIVATION;
                end
                I_LOAD_OUTPUT: begin
                    remaining_d = cmd_len;
                    region_d    = R_OUTPUT;
                end
                I_READ_ACTIVATION: remaining_d = cmd_len;
                default: err_d = 1'b1;
            endcase
        end
        if (wr_beat) begin
            remaining_d = remaining_q - LEN_ONE;
            case (region_q)
                R_WEIGHT:     wptr_d = wptr_q + ADDR_WIDTH'(1);
                R_ACTIVATION: aptr_d = aptr_q + ADDR_WIDTH'(1);
                default:      optr_d = optr_q + ADDR_WIDTH'(1);
            endcase
        end
        if (rd_issue) begin
            remaining_d = remaining_q - LEN_ONE;
            rptr_d      = rptr_q + ADDR_WIDTH'(1);
        end
    end

    // Output decode; strobes and address are combinational from state and handshakes
    always_comb begin
        cmd_ready   = (state_q == S_IDLE) && nrst;
        src_ready   = (state_q == S_WRITE);
        buf_wr_en   = wr_beat;
        buf_wr_data = (state_q == S_WRITE) ? src_data : {W{1'b0}};
        buf_rd_en   = rd_issue;
        buf_addr    = '0;
        if (state_q == S_WRITE) buf_addr = sel_ptr;
        if (state_q == S_READ)  buf_addr = rptr_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        err         = err_q;
    end

    assign rd_out_valid = buf_rd_data_valid;
    assign rd_out_data  = buf_rd_data;

endmodule

// File: tb/tb_gb_sequencer.sv
// tb/tb_gb_sequencer.sv - self-checking bench for gb_sequencer
module tb_gb_sequencer;

    localparam int AW = 32;
    localparam int W  = 128;
    localparam int LW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_instr;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] weight_start_addr, activation_start_addr, output_start_addr;
    logic          src_valid, src_ready;
    logic [W-1:0]  src_data;
    logic [AW-1:0] buf_addr;
    logic          buf_wr_en, buf_rd_en;
    logic [W-1:0]  buf_wr_data, buf_rd_data;
    logic          buf_rd_data_valid;
    logic          rd_out_ready, rd_out_valid;
    logic [W-1:0]  rd_out_data;
    logic          busy, done, err;

    int errors = 0;
    int checks = 0;

    wr_exp_t      wr_q[$];
    logic [W-1:0] rd_q[$];
    logic [W-1:0] mem    [0:1023];
    logic [W-1:0] shadow [0:1023];
    logic [AW-1:0] m_wptr, m_aptr, m_optr, m_rptr;

    gb_sequencer dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr), .cmd_len(cmd_len),
        .weight_start_addr(weight_start_addr), .activation_start_addr(activation_start_addr),
        .output_start_addr(output_start_addr),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .buf_addr(buf_addr), .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .buf_rd_data_valid(buf_rd_data_valid),
        .rd_out_ready(rd_out_ready), .rd_out_valid(rd_out_valid), .rd_out_data(rd_out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Global buffer model: one-cycle read latency
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_addr[9:0]] <= buf_wr_data;
        buf_rd_data_valid <= nrst ? buf_rd_en : 1'b0;
        buf_rd_data       <= mem[buf_addr[9:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next cycle slot (1ns after the rising edge)
    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle; returns in the slot after the accepting edge
    task automatic issue(input logic [3:0] instr, input logic [LW-1:0] len);
        cmd_valid = 1'b1;
        cmd_instr = instr;
        cmd_len   = len;
        next_slot();
        cmd_valid = 1'b0;
        cmd_instr = 4'd0;
        cmd_len   = '0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        cmd_valid = 1'b0; cmd_instr = '0; cmd_len = '0;
        weight_start_addr = '0; activation_start_addr = '0; output_start_addr = '0;
        src_valid = 1'b0; src_data = '0; rd_out_ready = 1'b0;
        buf_rd_data_valid = 1'b0; buf_rd_data = '0;
        m_wptr = '0; m_aptr = '0; m_optr = '0; m_rptr = '0;
        repeat (3) next_slot();
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%b busy=%b done=%b err=%b, required 0 0 0 0",
                     cmd_ready, busy, done, err);
        end
        nrst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        next_slot();
    endtask

    task automatic test_pointer_reset();
        weight_start_addr     = 32'h100;
        activation_start_addr = 32'h200;
        output_start_addr     = 32'h300;
        issue(4'd1, 16'd0);
        m_wptr = 32'h100; m_aptr = 32'h200; m_optr = 32'h300; m_rptr = 32'h200;
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ptr_reset_done: done=%b cmd_ready=%b err=%b busy=%b, required 1 0 0 1",
                     done, cmd_ready, err, busy);
        end
        next_slot();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ptr_reset_idle: done=%b cmd_ready=%b, required 0 1", done, cmd_ready);
        end
    endtask

    // One LOAD command; bubble=1 toggles src_valid 1,0,1,0...
    task automatic run_load(input logic [3:0] instr, input int len, input bit bubble);
        logic [AW-1:0] ptr;
        wr_exp_t       e;
        int            sent;
        int            k;
        logic          v;
        case (instr)
            4'd2:    ptr = m_wptr;
            4'd3:    ptr = m_aptr;
            default: ptr = m_optr;
        endcase
        issue(instr, LW'(len));
        sent = 0;
        k = 0;
        while (sent < len && k < 40) begin
            v = bubble ? (k % 2 == 0) : 1'b1;
            src_valid = v;
            src_data  = {$urandom, $urandom, $urandom, $urandom};
            if (v) begin
                e.addr = ptr;
                e.data = src_data;
                wr_q.push_back(e);
                shadow[ptr[9:0]] = src_data;
                ptr  = ptr + 1;
                sent++;
            end
            #1;
            checks++;
            if (buf_wr_en !== v || src_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL load_strobe i%0d k%0d: wr_en=%b src_ready=%b done=%b, required %b 1 0",
                         instr, k, buf_wr_en, src_ready, done, v);
            end
            if (buf_wr_en === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_extra_write: addr=%h, required no write", buf_addr);
                end else begin
                    e = wr_q.pop_front();
                    if (buf_addr !== e.addr || buf_wr_data !== e.data) begin
                        errors++;
                        $display("FAIL load_beat i%0d: addr=%h data=%h, required addr=%h data=%h",
                                 instr, buf_addr, buf_wr_data, e.addr, e.data);
                    end
                end
            end
            next_slot();
            k++;
        end
        src_valid = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || buf_wr_en !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done i%0d: done=%b wr_en=%b src_ready=%b, required 1 0 0",
                     instr, done, buf_wr_en, src_ready);
        end
        src_valid = 1'b0;
        next_slot();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_idle i%0d: cmd_ready=%b done=%b, required 1 0", instr, cmd_ready, done);
        end
        case (instr)
            4'd2:    m_wptr = ptr;
            4'd3:    m_aptr = ptr;
            default: m_optr = ptr;
        endcase
    endtask

    task automatic test_load_weight();
        run_load(4'd2, 3, 1'b0);
        run_load(4'd2, 1, 1'b0);
    endtask

    task automatic test_load_activation_bubbles();
        run_load(4'd3, 4, 1'b1);
    endtask

    task automatic test_read();
        logic [3:0]    pat;
        logic [W-1:0]  exp_d;
        logic          r;
        logic          prev_issue;
        int            issued;
        int            k;
        pat = 4'b1101;
        issued = 0;
        k = 0;
        prev_issue = 1'b0;
        issue(4'd5, 16'd3);
        while (issued < 3 && k < 20) begin
            r = (k < 4) ? pat[k] : 1'b1;
            rd_out_ready = r;
            #1;
            checks++;
            if (buf_rd_en !== r || buf_wr_en !== 1'b0 || (r && buf_addr !== m_rptr)) begin
                errors++;
                $display("FAIL read_issue k%0d: rd_en=%b wr_en=%b addr=%h, required %b 0 %h",
                         k, buf_rd_en, buf_wr_en, buf_addr, r, m_rptr);
            end
            checks++;
            if (rd_out_valid !== prev_issue) begin
                errors++;
                $display("FAIL read_valid k%0d: rd_out_valid=%b, required %b", k, rd_out_valid, prev_issue);
            end
            if (rd_out_valid === 1'b1 && rd_q.size() != 0) begin
                exp_d = rd_q.pop_front();
                checks++;
                if (rd_out_data !== exp_d) begin
                    errors++;
                    $display("FAIL read_data k%0d: data=%h, required %h", k, rd_out_data, exp_d);
                end
            end
            if (r) begin
                rd_q.push_back(shadow[m_rptr[9:0]]);
                m_rptr = m_rptr + 1;
                issued++;
            end
            prev_issue = r;
            next_slot();
            k++;
        end
        rd_out_ready = 1'b1;
        #1;
        checks++;
        if (buf_rd_en !== 1'b0 || rd_out_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_drain: rd_en=%b rd_out_valid=%b done=%b busy=%b, required 0 1 0 1",
                     buf_rd_en, rd_out_valid, done, busy);
        end
        if (rd_q.size() != 0) begin
            exp_d = rd_q.pop_front();
            checks++;
            if (rd_out_data !== exp_d) begin
                errors++;
                $display("FAIL read_last_data: data=%h, required %h", rd_out_data, exp_d);
            end
        end
        next_slot();
        checks++;
        if (done !== 1'b1 || buf_rd_en !== 1'b0 || rd_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_done: done=%b rd_en=%b rd_out_valid=%b, required 1 0 0",
                     done, buf_rd_en, rd_out_valid);
        end
        rd_out_ready = 1'b0;
        next_slot();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_idle: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_zero_len_and_err();
        issue(4'd4, 16'd0);
        src_valid = 1'b1;
        rd_out_ready = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b err=%b wr_en=%b rd_en=%b src_ready=%b, required 1 0 0 0 0",
                     done, err, buf_wr_en, buf_rd_en, src_ready);
        end
        src_valid = 1'b0;
        rd_out_ready = 1'b0;
        next_slot();
        issue(4'd9, 16'd5);
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL undef_instr: done=%b err=%b wr_en=%b rd_en=%b, required 1 1 0 0",
                     done, err, buf_wr_en, buf_rd_en);
        end
        next_slot();
        checks++;
        if (err !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL undef_after: err=%b done=%b cmd_ready=%b, required 0 0 1", err, done, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        issue(4'd2, 16'd5);
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'b1;
            src_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (buf_wr_en !== 1'b1 || buf_addr !== m_wptr + AW'(i)) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: wr_en=%b addr=%h, required 1 %h",
                         i, buf_wr_en, buf_addr, m_wptr + AW'(i));
            end
            next_slot();
        end
        src_valid = 1'b1;
        #1;
        nrst = 1'b0;
        #1;
        checks++;
        if (buf_wr_en !== 1'b0 || src_ready !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
            buf_addr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: wr_en=%b src_ready=%b busy=%b cmd_ready=%b addr=%h done=%b, required all 0",
                     buf_wr_en, src_ready, busy, cmd_ready, buf_addr, done);
        end
        next_slot();
        src_valid = 1'b0;
        nrst = 1'b1;
        m_wptr = '0; m_aptr = '0; m_optr = '0; m_rptr = '0;
        next_slot();
        run_load(4'd2, 1, 1'b0);
        run_load(4'd3, 1, 1'b0);
    endtask

    task automatic test_queues_empty();
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: wr_q=%0d rd_q=%0d, required 0 0", wr_q.size(), rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pointer_reset();
        test_load_weight();
        test_load_activation_bubbles();
        test_read();
        test_zero_len_and_err();
        test_reset_mid_write();
        test_queues_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
